// File: rtl/spi_mem_master.sv
// SPI mode-0 master for 32-bit word reads/writes to an external SPI memory.
// Each frame is {cmd, 24-bit addr, 32-bit data}, sent MSB first over a 64-bit shift.
module spi_mem_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              spi_clk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned     FRAME_W  = 8 + ADDR_W + DATA_W;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]      BIT_LAST = 7'(FRAME_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [6:0]           bit_q, bit_d;
  logic [FRAME_W-2:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]    rx_q, rx_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 we_q, we_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 sclk_q, sclk_d;
  logic                 ss_q, ss_d;
  logic                 mosi_q, mosi_d;
  logic                 miso_q;
  logic [FRAME_W-1:0]   frame;
  logic                 div_end;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;
    frame   = {(we ? 8'h02 : 8'h03), addr, (we ? wdata : '0)};
    div_end = (div_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SETUP;
          we_d    = we;
          mosi_d  = frame[FRAME_W-1];
          shreg_d = frame[FRAME_W-2:0];
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
        end
      end
      SETUP: begin
        if (div_end) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          rx_d    = {rx_q[DATA_W-2:0], miso_q};
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (!div_end) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          // High phase ends: drop clock and present next bit (none after the last).
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q != BIT_LAST) begin
              mosi_d  = shreg_q[FRAME_W-2];
              shreg_d = {shreg_q[FRAME_W-3:0], 1'b0};
            end
          end else if (bit_q == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q + 7'd1;
            rx_d   = {rx_q[DATA_W-2:0], miso_q};
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          state_d = DONE;
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          if (!we_q) rdata_d = rx_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
      miso_q  <= miso;
    end
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign busy    = busy_q;
  assign spi_clk = sclk_q;
  assign ss      = ss_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench for spi_mem_master: a CLK_DIV=2 instance with an SPI slave model
// and a CLK_DIV=1 instance used for back-to-back timing.
module tb_spi_mem_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req2, we2, ready2, busy2, sclk2, ss2, mosi2;
  logic [23:0] addr2;
  logic [31:0] wdata2, rdata2;
  logic        miso2 = 1'b0;

  logic        req1, we1, ready1, busy1, sclk1, ss1, mosi1;
  logic [23:0] addr1;
  logic [31:0] wdata1, rdata1;
  logic        miso1 = 1'b0;

  spi_mem_master #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .ready(ready2), .busy(busy2), .spi_clk(sclk2), .ss(ss2),
    .mosi(mosi2), .miso(miso2)
  );

  spi_mem_master #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ready(ready1), .busy(busy1), .spi_clk(sclk1), .ss(ss1),
    .mosi(mosi1), .miso(miso1)
  );

  int checks = 0;
  int failures = 0;

  // Slave model for the CLK_DIV=2 instance: loads slave_resp at ss fall, shifts on spi_clk fall.
  logic [63:0] slave_resp;
  logic [63:0] slv_sr2;
  logic [63:0] mosi_cap2;
  logic        sclk_p2 = 1'b0;
  logic        ss_p2 = 1'b1;
  int rises2 = 0, busy_cyc2 = 0, ready_cnt2 = 0, idle_err2 = 0;

  always @(negedge clk) begin
    if (sclk2 === 1'b1 && sclk_p2 === 1'b0) begin
      rises2++;
      mosi_cap2 = {mosi_cap2[62:0], mosi2};
    end
    if (ss2 === 1'b1 && sclk2 === 1'b1) idle_err2++;
    if (busy2 === 1'b1) busy_cyc2++;
    if (ready2 === 1'b1) ready_cnt2++;
    if (ss2 !== 1'b0) begin
      miso2 = 1'b0;
    end else if (ss_p2 === 1'b1) begin
      slv_sr2 = slave_resp;
      miso2   = slv_sr2[63];
    end else if (sclk2 === 1'b0 && sclk_p2 === 1'b1) begin
      slv_sr2 = slv_sr2 << 1;
      miso2   = slv_sr2[63];
    end
    sclk_p2 = sclk2;
    ss_p2   = ss2;
  end

  // Timing monitor for the CLK_DIV=1 instance.
  logic sclk_p1 = 1'b0, busy_p1 = 1'b0, ss_p1 = 1'b0;
  int rises1 = 0, bad_per1 = 0, idle_err1 = 0, since1 = 0, frame_r1 = 0;
  int busy_run1 = 0, ss_run1 = 0;
  int busy_runs1[$];
  int ss_gaps1[$];

  always @(negedge clk) begin
    since1++;
    if (ss1 === 1'b0 && ss_p1 === 1'b1) begin
      frame_r1 = 0;
      ss_gaps1.push_back(ss_run1);
      ss_run1 = 0;
    end
    if (ss1 === 1'b1) ss_run1++;
    if (sclk1 === 1'b1 && sclk_p1 === 1'b0) begin
      rises1++;
      if (frame_r1 > 0 && since1 != 2) bad_per1++;
      since1 = 0;
      frame_r1++;
    end
    if (ss1 === 1'b1 && sclk1 === 1'b1) idle_err1++;
    if (busy1 === 1'b1) begin
      busy_run1++;
    end else if (busy_p1 === 1'b1) begin
      busy_runs1.push_back(busy_run1);
      busy_run1 = 0;
    end
    sclk_p1 = sclk1;
    busy_p1 = busy1;
    ss_p1   = ss1;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer on the CLK_DIV=2 instance; optionally pulses req with inj_addr at cycle inj_at.
  task automatic run2(input string tag, input logic w, input logic [23:0] a, input logic [31:0] d,
                      input logic [63:0] exp_frame, input logic [31:0] exp_rdata,
                      input int inj_at, input logic [23:0] inj_addr);
    int r0, b0, k0, n;
    r0 = rises2; b0 = busy_cyc2; k0 = ready_cnt2;
    req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
    tick;
    req2 = 1'b0;
    chk({tag, "_busy_start"}, busy2, 1);
    chk({tag, "_ss_start"}, ss2, 0);
    chk({tag, "_mosi_first"}, mosi2, exp_frame[63]);
    n = 0;
    while (ready2 !== 1'b1 && n < 2000) begin
      if (n == inj_at) begin
        req2 = 1'b1; addr2 = inj_addr;
      end else begin
        req2 = 1'b0;
      end
      tick;
      n++;
    end
    req2 = 1'b0;
    chk({tag, "_ready"}, ready2, 1);
    chk({tag, "_rdata"}, rdata2, exp_rdata);
    chk({tag, "_ss_done"}, ss2, 1);
    tick;
    chk({tag, "_ready_one_cycle"}, ready2, 0);
    chk({tag, "_rises"}, rises2 - r0, 64);
    chk({tag, "_busy_cycles"}, busy_cyc2 - b0, 260);
    chk({tag, "_ready_count"}, ready_cnt2 - k0, 1);
    chk({tag, "_mosi_frame"}, mosi_cap2, exp_frame);
  endtask

  initial begin
    int r0, k0, n, seen;
    slave_resp = 64'hA5A5_5A5A_DEAD_BEEF;
    reset = 1'b1;
    req2 = 1'b1; we2 = 1'b0; addr2 = 24'h000100; wdata2 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    @(negedge clk);
    r0 = rises2;
    repeat (3) tick;
    chk("rst_ss", ss2, 1);
    chk("rst_sclk", sclk2, 0);
    chk("rst_mosi", mosi2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_ready", ready2, 0);
    chk("rst_rdata", rdata2, 0);
    chk("rst_no_edges", rises2 - r0, 0);
    reset = 1'b0; req2 = 1'b0;
    tick;

    run2("read", 1'b0, 24'h000100, 32'h0, 64'h0300_0100_0000_0000, 32'hDEADBEEF, -1, 24'h0);

    slave_resp = 64'h0F0F_F0F0_1234_5678;
    run2("write", 1'b1, 24'h123456, 32'hCAFEF00D, 64'h0212_3456_CAFE_F00D, 32'hDEADBEEF, -1, 24'h0);

    slave_resp = 64'hA5A5_5A5A_DEAD_BEEF;
    run2("busyreq", 1'b0, 24'h000ABC, 32'h0, 64'h0300_0ABC_0000_0000, 32'hDEADBEEF, 50, 24'h00FFFF);
    r0 = rises2;
    repeat (20) tick;
    chk("busyreq_no_second_busy", busy2, 0);
    chk("busyreq_no_second_frame", rises2 - r0, 0);

    r0 = rises2; k0 = ready_cnt2;
    req2 = 1'b1; we2 = 1'b0; addr2 = 24'h000200;
    tick;
    req2 = 1'b0;
    n = 0;
    while (rises2 - r0 < 20 && n < 1000) begin
      tick;
      n++;
    end
    chk("rstmid_reach20", rises2 - r0, 20);
    reset = 1'b1;
    tick;
    chk("rstmid_ss", ss2, 1);
    chk("rstmid_sclk", sclk2, 0);
    chk("rstmid_busy", busy2, 0);
    chk("rstmid_ready", ready2, 0);
    chk("rstmid_mosi", mosi2, 0);
    chk("rstmid_rdata", rdata2, 0);
    reset = 1'b0;
    repeat (300) tick;
    chk("rstmid_no_ready", ready_cnt2 - k0, 0);
    chk("rstmid_no_more_edges", rises2 - r0, 20);
    run2("read_after_rst", 1'b0, 24'h000300, 32'h0, 64'h0300_0300_0000_0000, 32'hDEADBEEF, -1, 24'h0);
    chk("idle_sclk_dut2", idle_err2, 0);

    r0 = rises1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 24'h000040;
    seen = 0; n = 0;
    while (seen < 2 && n < 1000) begin
      tick;
      n++;
      if (ready1 === 1'b1) begin
        seen++;
        if (seen == 2) req1 = 1'b0;
      end
    end
    req1 = 1'b0;
    repeat (5) tick;
    chk("b2b_ready_pulses", seen, 2);
    chk("b2b_busy_runs", busy_runs1.size(), 2);
    chk("b2b_busy0", (busy_runs1.size() >= 1) ? busy_runs1[0] : -1, 130);
    chk("b2b_busy1", (busy_runs1.size() >= 2) ? busy_runs1[1] : -1, 130);
    chk("b2b_gap", (ss_gaps1.size() >= 2) ? ss_gaps1[1] : -1, 2);
    chk("b2b_rises", rises1 - r0, 128);
    chk("b2b_period", bad_per1, 0);
    chk("b2b_idle_sclk", idle_err1, 0);
    chk("b2b_no_third", busy1, 0);
    chk("b2b_rdata", rdata1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
